lfsr_run_ctrl: RTL

//  Sequencer for the max-length LFSR symbol source (lfsr_gen_max) and the downstream

---
 rtl/lfsr_run_ctrl_pkg.sv | 29 ++
 rtl/lfsr_run_ctrl_window.sv | 59 +++++
 rtl/lfsr_run_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_run_ctrl_pkg
//  Description : Shared types and helpers for the LFSR run controller.
//                - ctrl_state_t : controller state encoding (3 bits)
//                - c_LFSR_LEN_DEFAULT : default LFSR length
//                - sym_cnt_width() : width of the symbol counter
//  Revision    : 1.0  initial release
// ============================================================================
package lfsr_run_ctrl_pkg;

  typedef enum logic [2:0] {
    CTRL_IDLE = 3'd0,
    CTRL_SEED = 3'd1,
    CTRL_RUN  = 3'd2,
    CTRL_DUMP = 3'd3,
    CTRL_DONE = 3'd4
  } ctrl_state_t;

  localparam int c_LFSR_LEN_DEFAULT = 22;

  // One extra bit above the full-run count so that PIPE_DLY added on top of
  // CYCLES*PERIOD can never wrap the counter.
  function automatic int sym_cnt_width(input int lfsr_len, input int cycles);
    return lfsr_len + $clog2(cycles) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_run_ctrl_window.sv
`default_nettype none
// ============================================================================
//  Module      : sym_window_counter
//  Description : Counts symbol strobes across one run and tracks the expected
//                LFSR phase.
//                Ports: clk, reset (async, high), clear (restart count),
//                strobe (count one symbol), phase (expected LFSR counter
//                value for the current strobe), last_strobe (current strobe
//                is the final one of the run), in_window (current strobe lies
//                inside the accumulate window).
//  Revision    : 1.0  initial release
// ============================================================================
module sym_window_counter
  import lfsr_run_ctrl_pkg::*;
#(
  parameter int LFSR_LEN = c_LFSR_LEN_DEFAULT,
  parameter int CYCLES   = 4,
  parameter int PIPE_DLY = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                strobe,
  output logic [LFSR_LEN-1:0] phase,
  output logic                last_strobe,
  output logic                in_window
);

  localparam int CNT_W  = sym_cnt_width(LFSR_LEN, CYCLES);
  localparam int PERIOD = (1 << LFSR_LEN) - 1;

  localparam logic [CNT_W-1:0]    c_TOTAL_M1 = CNT_W'(CYCLES * PERIOD + PIPE_DLY - 1);
  localparam logic [CNT_W-1:0]    c_PIPE_DLY = CNT_W'(PIPE_DLY);
  localparam logic [LFSR_LEN-1:0] c_PERIOD   = LFSR_LEN'(PERIOD);
  localparam logic [LFSR_LEN-1:0] c_PHASE1   = LFSR_LEN'(1);

  logic [CNT_W-1:0]    r_sym_cnt;
  logic [LFSR_LEN-1:0] r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym_cnt <= '0;
      r_phase   <= c_PHASE1;
    end else if (clear) begin
      r_sym_cnt <= '0;
      r_phase   <= c_PHASE1;
    end else if (strobe) begin
      r_sym_cnt <= r_sym_cnt + CNT_W'(1);
      // The LFSR counter never shows 0, so the phase wraps straight to 1.
      r_phase   <= (r_phase == c_PERIOD) ? c_PHASE1 : r_phase + LFSR_LEN'(1);
    end
  end

  assign phase       = r_phase;
  assign last_strobe = (r_sym_cnt == c_TOTAL_M1);
  assign in_window   = (r_sym_cnt >= c_PIPE_DLY);

endmodule
`default_nettype wire

// File: rtl/lfsr_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_run_ctrl
//  Description : Run sequencer for the max-length LFSR symbol source and the
//                reference-level accumulators. Seeds the LFSR, runs it for
//                CYCLES full periods, opens the accumulate window PIPE_DLY
//                strobes late, dumps and reports done. Cross-checks the
//                generator's own cycle counter against the expected phase.
//                Ports: clk, reset (async, high), start, abort, sym_strobe,
//                lfsr_counter | lfsr_clk_en, lfsr_reset, acc_clear, acc_en,
//                acc_dump, busy, done, sync_err, aborted.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_run_ctrl
  import lfsr_run_ctrl_pkg::*;
#(
  parameter int LFSR_LEN = c_LFSR_LEN_DEFAULT,
  parameter int CYCLES   = 4,
  parameter int PIPE_DLY = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                sym_strobe,
  input  logic [LFSR_LEN-1:0] lfsr_counter,
  output logic                lfsr_clk_en,
  output logic                lfsr_reset,
  output logic                acc_clear,
  output logic                acc_en,
  output logic                acc_dump,
  output logic                busy,
  output logic                done,
  output logic                sync_err,
  output logic                aborted
);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic                w_run_strobe;
  logic                w_abort_take;
  logic                w_last_strobe;
  logic                w_in_window;
  logic [LFSR_LEN-1:0] w_phase;

  logic r_lfsr_reset;
  logic r_acc_clear;
  logic r_acc_dump;
  logic r_busy;
  logic r_done;
  logic r_sync_err;
  logic r_aborted;

  assign w_run_strobe = (r_state == CTRL_RUN) && sym_strobe;
  assign w_abort_take = abort && ((r_state == CTRL_SEED) ||
                                  (r_state == CTRL_RUN)  ||
                                  (r_state == CTRL_DUMP));

  sym_window_counter #(
    .LFSR_LEN (LFSR_LEN),
    .CYCLES   (CYCLES),
    .PIPE_DLY (PIPE_DLY)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .clear       (r_state == CTRL_SEED),
    .strobe      (w_run_strobe),
    .phase       (w_phase),
    .last_strobe (w_last_strobe),
    .in_window   (w_in_window)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CTRL_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CTRL_IDLE, CTRL_DONE: if (start && !abort) w_state_nxt = CTRL_SEED;
      CTRL_SEED:            w_state_nxt = CTRL_RUN;
      CTRL_RUN:             if (w_run_strobe && w_last_strobe) w_state_nxt = CTRL_DUMP;
      CTRL_DUMP:            w_state_nxt = CTRL_DONE;
      default:              w_state_nxt = CTRL_IDLE;
    endcase
    if (w_abort_take) w_state_nxt = CTRL_IDLE;
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe rather than trailing it by a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr_reset <= 1'b0;
      r_acc_clear  <= 1'b0;
      r_acc_dump   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sync_err   <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_lfsr_reset <= (w_state_nxt == CTRL_SEED);
      r_acc_clear  <= (w_state_nxt == CTRL_SEED);
      r_acc_dump   <= (w_state_nxt == CTRL_DUMP);
      r_busy       <= (w_state_nxt == CTRL_SEED) || (w_state_nxt == CTRL_RUN) ||
                      (w_state_nxt == CTRL_DUMP);
      r_done       <= (w_state_nxt == CTRL_DONE);
      r_aborted    <= w_abort_take;
      if (w_state_nxt == CTRL_SEED)
        r_sync_err <= 1'b0;
      else if (w_run_strobe && (lfsr_counter != w_phase))
        r_sync_err <= 1'b1;
    end
  end

  assign lfsr_clk_en = w_run_strobe;
  assign acc_en      = w_run_strobe && w_in_window;
  assign lfsr_reset  = r_lfsr_reset;
  assign acc_clear   = r_acc_clear;
  assign acc_dump    = r_acc_dump;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sync_err    = r_sync_err;
  assign aborted     = r_aborted;

endmodule
`default_nettype wire
